hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that drives the stall, flush and forwarding controls consumed by the fetch, decode→execute, execute→memory and memory→writeback pipeline registers. It generates the execute-stage flush (bubble) request, load-use stalls, multicycle-execute holds and memory-busy freezes, and selects the forwarding sources for execute-stage operands. It also keeps saturating performance counters. It sits beside the datapath, in the core top level.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- LOAD_SRC, 3'b001, result_src encoding that identifies a load in execute
- EX_TIMEOUT, 64, maximum cycles spent in EX_BUSY before a forced release
- CNT_W, 32, performance counter width

Ports:
- i_clk  in  1  clock
- i_arstn  in  1  asynchronous active-low reset
- i_de_rs1_addr, i_de_rs2_addr  in  REG_ADDR_W  decode-stage source addresses
- i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr  in  REG_ADDR_W  execute-stage addresses
- i_ex_result_src  in  3  execute-stage result source
- i_mem_rd_addr, i_wb_rd_addr  in  REG_ADDR_W  memory/writeback destination addresses
- i_mem_reg_we, i_wb_reg_we  in  1  memory/writeback register write enables
- i_branch_taken  in  1  execute-stage redirect (taken branch or jump)
- i_ex_mc_start  in  1  multicycle op (mul/div) present in execute, first cycle
- i_ex_done  in  1  multicycle unit result valid
- i_mem_busy  in  1  data memory/cache not ready
- i_cnt_clr  in  1  synchronous counter clear
- o_stall_fetch, o_stall_decode, o_stall_exec, o_stall_mem  out  1  hold the corresponding stage register
- o_flush_decode, o_flush_exec, o_flush_mem  out  1  load a bubble into the corresponding stage register
- o_forward_rs1, o_forward_rs2  out  2  00 = register file, 10 = memory stage, 01 = writeback stage
- o_ex_timeout  out  1  one-cycle pulse on forced EX_BUSY release
- o_stall_cycles, o_flush_count  out  CNT_W  performance counters

## Operation
- Forwarding is combinational and applies independently to rs1 and rs2:
  - Select 10 if i_mem_reg_we, the mem rd ≠ 0, and the mem rd equals the ex rs address.
  - Otherwise select 01 under the same test against writeback.
  - Otherwise select 00.
  - Memory has priority over writeback.
- load_use = (i_ex_result_src == LOAD_SRC) && i_ex_rd_addr ≠ 0 && (i_ex_rd_addr == i_de_rs1_addr || i_ex_rd_addr == i_de_rs2_addr).
- The FSM has two states, RUN and EX_BUSY. Control priority per cycle: i_mem_busy, then EX_BUSY, then i_branch_taken, then i_ex_mc_start, then load_use.
- i_mem_busy, in any state:
  - All four stalls = 1; all flushes = 0.
  - The FSM state and timeout counter hold.
- RUN, not busy:
  - i_branch_taken: o_flush_decode = o_flush_exec = 1; stalls = 0. The branch overrides load_use.
  - i_ex_mc_start: o_stall_fetch, o_stall_decode, o_stall_exec = 1 and o_flush_mem = 1. Go to EX_BUSY and clear the timeout counter.
  - load_use: o_stall_fetch = o_stall_decode = 1 and o_flush_exec = 1.
- EX_BUSY, not busy:
  - Drive o_stall_fetch, o_stall_decode, o_stall_exec = 1 and o_flush_mem = 1, and increment the timeout counter.
  - i_ex_done releases the hold: that cycle all outputs are 0 and the next state is RUN.
  - If the counter reaches EX_TIMEOUT−1 without i_ex_done: release as for done, pulse o_ex_timeout, go to RUN.
  - i_branch_taken and load_use are ignored in EX_BUSY.
- Counters:
  - o_stall_cycles increments on every cycle with o_stall_fetch = 1.
  - o_flush_count increments on every cycle with a branch flush.
  - Both saturate at all-ones.
  - i_cnt_clr zeroes both and takes priority over increment.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the current state, valid in the same cycle.
- The state, timeout counter, perf counters and o_ex_timeout are registered and update on the rising edge of i_clk.
- Reset (i_arstn = 0, asynchronous, mid-operation included):
  - State = RUN; timeout counter = 0; o_ex_timeout = 0; o_stall_cycles = o_flush_count = 0.
  - Combinational outputs evaluate from RUN.
- o_ex_timeout is high for exactly the cycle after the forced release edge.
- EX_BUSY minimum length is 1 cycle. An i_ex_done in the same cycle as i_ex_mc_start is ignored; done is only accepted in EX_BUSY.

## Test plan
- Forwarding: mem rd = 5 with we, wb rd = 5 with we, ex rs1 = 5 -> o_forward_rs1 = 10. Mem we = 0 -> 01. Rd = 0 everywhere -> 00.
- Load-use: ex result_src = 001, ex rd = 7, de rs2 = 7 -> stall_fetch/decode = 1 and flush_exec = 1 for one cycle; o_stall_cycles +1.
- Branch plus load_use in the same cycle -> flush_decode = flush_exec = 1, stalls = 0, o_flush_count +1.
- Multicycle: i_ex_mc_start, then i_ex_done after 4 cycles -> 5 cycles of stall_fetch/decode/exec and flush_mem, then all 0 on the done cycle, state RUN.
- Timeout: i_ex_mc_start with no done -> forced release after EX_TIMEOUT = 64 cycles; o_ex_timeout is a 1-cycle pulse.
- i_mem_busy asserted for 3 cycles during EX_BUSY, then reset asserted mid-EX_BUSY -> all stalls = 1 and state held during busy; reset returns all counters to 0 and the state to RUN immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and multicycle stalls,
// branch flushes, memory-busy freezes and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int         REG_ADDR_W = 5,
   parameter logic [2:0] LOAD_SRC   = 3'b001,
   parameter int         EX_TIMEOUT = 64,
   parameter int         CNT_W      = 32
) (
   input  logic                  i_clk,
   input  logic                  i_arstn,
   input  logic [REG_ADDR_W-1:0] i_de_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_de_rs2_addr,
   input  logic [REG_ADDR_W-1:0] i_ex_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_ex_rs2_addr,
   input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
   input  logic [2:0]            i_ex_result_src,
   input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
   input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
   input  logic                  i_mem_reg_we,
   input  logic                  i_wb_reg_we,
   input  logic                  i_branch_taken,
   input  logic                  i_ex_mc_start,
   input  logic                  i_ex_done,
   input  logic                  i_mem_busy,
   input  logic                  i_cnt_clr,
   output logic                  o_stall_fetch,
   output logic                  o_stall_decode,
   output logic                  o_stall_exec,
   output logic                  o_stall_mem,
   output logic                  o_flush_decode,
   output logic                  o_flush_exec,
   output logic                  o_flush_mem,
   output logic [1:0]            o_forward_rs1,
   output logic [1:0]            o_forward_rs2,
   output logic                  o_ex_timeout,
   output logic [CNT_W-1:0]      o_stall_cycles,
   output logic [CNT_W-1:0]      o_flush_count
);

   localparam int TW = $clog2(EX_TIMEOUT) + 1;

   typedef enum logic {RUN, EX_BUSY} state_t;

   state_t        state;
   logic [TW-1:0] tmo_cnt;
   logic          mem_ok, wb_ok, load_use, tmo_hit, release_hold;

   assign mem_ok = i_mem_reg_we && (i_mem_rd_addr != '0);
   assign wb_ok  = i_wb_reg_we  && (i_wb_rd_addr  != '0);

   // Memory stage holds the younger result, so it wins over writeback.
   assign o_forward_rs1 = (mem_ok && i_mem_rd_addr == i_ex_rs1_addr) ? 2'b10 :
                          (wb_ok  && i_wb_rd_addr  == i_ex_rs1_addr) ? 2'b01 : 2'b00;
   assign o_forward_rs2 = (mem_ok && i_mem_rd_addr == i_ex_rs2_addr) ? 2'b10 :
                          (wb_ok  && i_wb_rd_addr  == i_ex_rs2_addr) ? 2'b01 : 2'b00;

   assign load_use = (i_ex_result_src == LOAD_SRC) && (i_ex_rd_addr != '0) &&
                     ((i_ex_rd_addr == i_de_rs1_addr) || (i_ex_rd_addr == i_de_rs2_addr));

   assign tmo_hit      = (tmo_cnt == TW'(EX_TIMEOUT - 1));
   assign release_hold = (state == EX_BUSY) && (i_ex_done || tmo_hit);

   always_comb begin
      o_stall_fetch  = 1'b0;
      o_stall_decode = 1'b0;
      o_stall_exec   = 1'b0;
      o_stall_mem    = 1'b0;
      o_flush_decode = 1'b0;
      o_flush_exec   = 1'b0;
      o_flush_mem    = 1'b0;
      if (i_mem_busy) begin
         o_stall_fetch  = 1'b1;
         o_stall_decode = 1'b1;
         o_stall_exec   = 1'b1;
         o_stall_mem    = 1'b1;
      end else if (state == EX_BUSY) begin
         if (!release_hold) begin
            o_stall_fetch  = 1'b1;
            o_stall_decode = 1'b1;
            o_stall_exec   = 1'b1;
            o_flush_mem    = 1'b1;
         end
      end else if (i_branch_taken) begin
         o_flush_decode = 1'b1;
         o_flush_exec   = 1'b1;
      end else if (i_ex_mc_start) begin
         o_stall_fetch  = 1'b1;
         o_stall_decode = 1'b1;
         o_stall_exec   = 1'b1;
         o_flush_mem    = 1'b1;
      end else if (load_use) begin
         o_stall_fetch  = 1'b1;
         o_stall_decode = 1'b1;
         o_flush_exec   = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         state          <= RUN;
         tmo_cnt        <= '0;
         o_ex_timeout   <= 1'b0;
         o_stall_cycles <= '0;
         o_flush_count  <= '0;
      end else begin
         // A done arriving together with the timeout is a normal release.
         o_ex_timeout <= !i_mem_busy && (state == EX_BUSY) && !i_ex_done && tmo_hit;
         if (!i_mem_busy) begin
            case (state)
               RUN: if (!i_branch_taken && i_ex_mc_start) begin
                  state   <= EX_BUSY;
                  tmo_cnt <= '0;
               end
               EX_BUSY: if (release_hold) state <= RUN;
                        else tmo_cnt <= tmo_cnt + 1'b1;
               default: state <= RUN;
            endcase
         end
         if (i_cnt_clr) begin
            o_stall_cycles <= '0;
            o_flush_count  <= '0;
         end else begin
            if (o_stall_fetch && !(&o_stall_cycles)) o_stall_cycles <= o_stall_cycles + CNT_W'(1);
            // Only a branch redirect raises the decode flush.
            if (o_flush_decode && !(&o_flush_count)) o_flush_count <= o_flush_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed test-plan steps followed by random traffic,
// all checked against a cycle-level behavioural model.
module tb_hazard_ctrl;
   localparam int         AW    = 5;
   localparam logic [2:0] LDS   = 3'b001;
   localparam int         TMO   = 64;
   localparam int         CW    = 6;
   localparam longint     CMAX  = (longint'(1) << CW) - 1;

   logic          i_clk = 1'b0, i_arstn = 1'b0;
   logic [AW-1:0] de_rs1 = '0, de_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0;
   logic [AW-1:0] mem_rd = '0, wb_rd = '0;
   logic [2:0]    res_src = '0;
   logic          mem_we = 0, wb_we = 0, branch = 0, mc = 0, done = 0, mbusy = 0, clr = 0;
   logic          sf, sd, se, sm, fd, fe, fm, tmo;
   logic [1:0]    f1, f2;
   logic [CW-1:0] sc, fc;

   int n_tests = 0, n_fail = 0;

   // behavioural model state
   bit     m_busy = 0;
   int     m_wait = 0;
   bit     m_tmo  = 0;
   longint m_sc = 0, m_fc = 0;
   int     tmo_pulses = 0, stall_seen = 0;

   hazard_ctrl #(.REG_ADDR_W(AW), .LOAD_SRC(LDS), .EX_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .i_clk(i_clk), .i_arstn(i_arstn),
      .i_de_rs1_addr(de_rs1), .i_de_rs2_addr(de_rs2),
      .i_ex_rs1_addr(ex_rs1), .i_ex_rs2_addr(ex_rs2), .i_ex_rd_addr(ex_rd),
      .i_ex_result_src(res_src),
      .i_mem_rd_addr(mem_rd), .i_wb_rd_addr(wb_rd),
      .i_mem_reg_we(mem_we), .i_wb_reg_we(wb_we),
      .i_branch_taken(branch), .i_ex_mc_start(mc), .i_ex_done(done),
      .i_mem_busy(mbusy), .i_cnt_clr(clr),
      .o_stall_fetch(sf), .o_stall_decode(sd), .o_stall_exec(se), .o_stall_mem(sm),
      .o_flush_decode(fd), .o_flush_exec(fe), .o_flush_mem(fm),
      .o_forward_rs1(f1), .o_forward_rs2(f2),
      .o_ex_timeout(tmo), .o_stall_cycles(sc), .o_flush_count(fc)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
      if (mem_we && mem_rd != 0 && mem_rd == rs) return 2'b10;
      if (wb_we && wb_rd != 0 && wb_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   // One cycle: check outputs mid-cycle, then advance the model at the edge.
   task automatic step();
      logic [6:0] ctl;
      bit lu, rel, br_flush;
      #1;
      lu  = (res_src == LDS) && ex_rd != 0 && (ex_rd == de_rs1 || ex_rd == de_rs2);
      rel = m_busy && (done || m_wait == TMO - 1);
      ctl = 7'b0;  // {sf,sd,se,sm,fd,fe,fm}
      if (mbusy)             ctl = 7'b1111000;
      else if (m_busy)       ctl = rel ? 7'b0000000 : 7'b1110001;
      else if (branch)       ctl = 7'b0000110;
      else if (mc)           ctl = 7'b1110001;
      else if (lu)           ctl = 7'b1100010;
      chk("fwd_rs1", f1, m_fwd(ex_rs1));
      chk("fwd_rs2", f2, m_fwd(ex_rs2));
      chk("ctl", {sf, sd, se, sm, fd, fe, fm}, ctl);
      chk("ex_timeout", tmo, m_tmo);
      chk("stall_cycles", sc, m_sc);
      chk("flush_count", fc, m_fc);
      if (tmo) tmo_pulses++;
      if (sf) stall_seen++;
      br_flush = ctl[2];
      @(posedge i_clk);
      m_tmo = !mbusy && m_busy && !done && (m_wait == TMO - 1);
      if (clr) begin
         m_sc = 0; m_fc = 0;
      end else begin
         if (ctl[6] && m_sc < CMAX) m_sc++;
         if (br_flush && m_fc < CMAX) m_fc++;
      end
      if (!mbusy) begin
         if (m_busy) begin
            if (rel) m_busy = 0; else m_wait++;
         end else if (!branch && mc) begin
            m_busy = 1; m_wait = 0;
         end
      end
      #1;
   endtask

   task automatic quiet();
      de_rs1 = 0; de_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
      res_src = 0; mem_we = 0; wb_we = 0; branch = 0; mc = 0; done = 0; mbusy = 0; clr = 0;
   endtask

   initial begin
      #12;
      chk("rst_stall_cycles", sc, 0);
      chk("rst_flush_count", fc, 0);
      chk("rst_timeout", tmo, 0);
      chk("rst_ctl", {sf, sd, se, sm, fd, fe, fm}, 0);
      i_arstn = 1'b1;

      // forwarding priority
      mem_rd = 5; mem_we = 1; wb_rd = 5; wb_we = 1; ex_rs1 = 5;
      #1 chk("fwd_mem_pri", f1, 2'b10);
      step();
      mem_we = 0;
      #1 chk("fwd_wb", f1, 2'b01);
      step();
      mem_rd = 0; wb_rd = 0; mem_we = 1; ex_rs1 = 0; ex_rs2 = 0;
      step();

      // load-use
      quiet(); res_src = 3'b001; ex_rd = 7; de_rs2 = 7;
      step();
      quiet();
      step();
      chk("lu_stall_count", sc, 1);

      // branch overrides load-use
      res_src = 3'b001; ex_rd = 7; de_rs1 = 7; branch = 1;
      step();
      quiet();
      step();
      chk("br_flush_count", fc, 1);

      // multicycle op, done after 4 cycles
      stall_seen = 0;
      mc = 1; step(); mc = 0;
      repeat (4) step();
      done = 1; step(); done = 0;
      step();
      chk("mc_stall_cycles", stall_seen, 5);

      // counter clear
      clr = 1; step(); clr = 0; step();

      // forced release on timeout
      tmo_pulses = 0;
      mc = 1; step(); mc = 0;
      repeat (TMO + 4) step();
      chk("tmo_pulse_count", tmo_pulses, 1);
      chk("stall_saturated", sc, CMAX);
      clr = 1; step(); clr = 0;

      // mem busy during EX_BUSY, then asynchronous reset mid-hold
      mc = 1; step(); mc = 0;
      step();
      mbusy = 1; repeat (3) step(); mbusy = 0;
      step();
      #1 i_arstn = 1'b0;
      #1;
      chk("arst_stall_cycles", sc, 0);
      chk("arst_flush_count", fc, 0);
      chk("arst_timeout", tmo, 0);
      chk("arst_run_state", {sf, sd, se, fm}, 0);
      m_busy = 0; m_wait = 0; m_tmo = 0; m_sc = 0; m_fc = 0;
      i_arstn = 1'b1;

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         de_rs1 = AW'($urandom_range(0, 3)); de_rs2 = AW'($urandom_range(0, 3));
         ex_rs1 = AW'($urandom_range(0, 3)); ex_rs2 = AW'($urandom_range(0, 3));
         ex_rd  = AW'($urandom_range(0, 3));
         mem_rd = AW'($urandom_range(0, 3)); wb_rd = AW'($urandom_range(0, 3));
         res_src = ($urandom_range(0, 1) != 0) ? LDS : 3'($urandom_range(0, 7));
         mem_we = 1'($urandom_range(0, 1)); wb_we = 1'($urandom_range(0, 1));
         branch = ($urandom_range(0, 5) == 0);
         mc     = ($urandom_range(0, 9) == 0);
         done   = ($urandom_range(0, 7) == 0);
         mbusy  = ($urandom_range(0, 7) == 0);
         clr    = ($urandom_range(0, 49) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
